div_uint_seq: RTL

- Sequential unsigned integer divider. It is the inverse counterpart of the combinational n-bit multiplier, and it is used where quotient and remainder are needed.
- Uses a restoring shift-subtract algorithm that resolves one quotient bit per cycle.
- Valid/ready handshakes on both the operand side and the result side, so it can sit between pipeline stages in PIM arithmetic test designs.

---
 rtl/div_uint_seq_if.sv | 14 +
 rtl/div_uint_seq.sv | 78 +++++++
 2 files changed

// File: rtl/div_uint_seq_if.sv
// div_uint_seq_if: operand/result valid-ready bundle for the sequential divider.
interface div_uint_seq_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;
  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Q, R, div_by_zero);
  modport slave  (input in_valid, A, B, out_ready, output in_ready, out_valid, Q, R, div_by_zero);
endinterface

// File: rtl/div_uint_seq.sv
// div_uint_seq: restoring shift-subtract unsigned divider, one quotient bit per cycle.
module div_uint_seq #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  div_uint_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] ZDIV = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] dvd, dvs, rem, q, r;
  logic [CW-1:0]    cnt;
  logic             dbz;
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] rem_nx, dvd_nx;

  // The extra bit keeps a shifted remainder with its MSB set comparable to the divisor;
  // diff[WIDTH] is the borrow, i.e. rem_sh < divisor.
  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    rem_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    dvd_nx = {dvd[WIDTH-2:0], ~diff[WIDTH]};
  end

  // ZDIV spends the single cycle a divide-by-zero takes before its result is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dbz   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          dvd   <= bus.A;
          dvs   <= bus.B;
          rem   <= '0;
          cnt   <= CW'(WIDTH);
          state <= (bus.B == '0) ? ZDIV : CALC;
        end
        CALC: begin
          dvd <= dvd_nx;
          rem <= rem_nx;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            q     <= dvd_nx;
            r     <= rem_nx;
            dbz   <= 1'b0;
            state <= DONE;
          end
        end
        ZDIV: begin
          q     <= '1;
          r     <= dvd;
          dbz   <= 1'b1;
          state <= DONE;
        end
        default: if (bus.out_ready) state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = state == IDLE;
  assign bus.out_valid   = state == DONE;
  assign bus.Q           = q;
  assign bus.R           = r;
  assign bus.div_by_zero = dbz;
endmodule
